// File: rtl/systola_pkg.sv
// Shared definitions for the systolic array column logic: default sizes,
// width helper and drain order encoding.
package systola_pkg;

  localparam int ROWS_DEF     = 8;
  localparam int OUTWIDTH_DEF = 32;

  typedef enum logic {
    ORD_FWD = 1'b0,
    ORD_REV = 1'b1
  } drain_order_e;

  // Width of an index/count able to hold n distinct values, never below one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/col_slot.sv
// One result slot of a column drain buffer: data register plus full flag,
// with same-cycle refill during drain and an overflow pulse on dropped writes.
module col_slot
  import systola_pkg::*;
#(
  parameter int OUTWIDTH = OUTWIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_v,
  input  logic [OUTWIDTH-1:0] wr_data,
  input  logic                drain,
  output logic [OUTWIDTH-1:0] data,
  output logic                full,
  output logic                full_nxt,
  output logic                ovf_pulse
);

  logic [OUTWIDTH-1:0] data_r;
  logic                full_r;
  logic [OUTWIDTH-1:0] data_nxt_s;
  logic                full_nxt_s;
  logic                ovf_pulse_s;

  // Next-state for the slot: a write lands if the slot is empty or draining now.
  always_comb begin
    data_nxt_s  = data_r;
    full_nxt_s  = full_r;
    ovf_pulse_s = 1'b0;
    if (wr_v && (!full_r || drain)) begin
      data_nxt_s = wr_data;
      full_nxt_s = 1'b1;
    end else if (wr_v) begin
      ovf_pulse_s = 1'b1;
    end else if (drain) begin
      full_nxt_s = 1'b0;
    end else begin
      full_nxt_s = full_r;
    end
  end

  // Slot state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= '0;
      full_r <= 1'b0;
    end else begin
      data_r <= data_nxt_s;
      full_r <= full_nxt_s;
    end
  end

  assign data      = data_r;
  assign full      = full_r;
  assign full_nxt  = full_nxt_s;
  assign ovf_pulse = ovf_pulse_s;

endmodule

// File: rtl/col_drain_buffer.sv
// Per-column result collector: captures one result per PE row and drains them
// in strict row order (forward or reverse) over a valid/ready stream.
module col_drain_buffer
  import systola_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int OUTWIDTH = OUTWIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [OUTWIDTH-1:0]             in_r [0:ROWS-1],
  input  logic                            in_v [0:ROWS-1],
  input  logic                            rev_order,
  input  logic                            clr_ovf,
  output logic [OUTWIDTH-1:0]             out_data,
  output logic [clog2_min1(ROWS)-1:0]     out_row,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic [clog2_min1(ROWS+1)-1:0]   occupancy,
  output logic                            busy,
  output logic                            overflow
);

  localparam int PTR_W = clog2_min1(ROWS);
  localparam int CNT_W = clog2_min1(ROWS + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(ROWS - 1);

  logic [PTR_W-1:0]    ptr_r;
  drain_order_e        order_r;
  logic [CNT_W-1:0]    occ_r;
  logic                ovf_r;

  logic [OUTWIDTH-1:0] slot_data_s [0:ROWS-1];
  logic [ROWS-1:0]     full_s;
  logic [ROWS-1:0]     full_nxt_s;
  logic [ROWS-1:0]     ovf_pulse_s;
  logic [ROWS-1:0]     slot_drain_s;
  logic [PTR_W-1:0]    first_row_s;
  logic [PTR_W-1:0]    last_row_s;
  logic [PTR_W-1:0]    ptr_step_s;
  logic [CNT_W-1:0]    occ_nxt_s;
  logic                valid_s;
  logic                hs_s;
  logic                busy_s;

  for (genvar i = 0; i < ROWS; i++) begin : g_slot
    assign slot_drain_s[i] = hs_s && (ptr_r == PTR_W'(i));

    col_slot #(
      .OUTWIDTH (OUTWIDTH)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .wr_v      (in_v[i]),
      .wr_data   (in_r[i]),
      .drain     (slot_drain_s[i]),
      .data      (slot_data_s[i]),
      .full      (full_s[i]),
      .full_nxt  (full_nxt_s[i]),
      .ovf_pulse (ovf_pulse_s[i])
    );
  end

  assign valid_s = full_s[ptr_r];
  assign hs_s    = valid_s && out_ready;
  assign busy_s  = (occ_r != CNT_W'(0)) || (ptr_r != first_row_s);

  // Ends of the current drain order and the pointer's successor.
  always_comb begin
    case (order_r)
      ORD_FWD: begin
        first_row_s = PTR_W'(0);
        last_row_s  = LAST_IDX;
      end
      ORD_REV: begin
        first_row_s = LAST_IDX;
        last_row_s  = PTR_W'(0);
      end
      default: begin
        first_row_s = PTR_W'(0);
        last_row_s  = LAST_IDX;
      end
    endcase
    if (ptr_r == last_row_s) begin
      ptr_step_s = first_row_s;
    end else if (order_r == ORD_REV) begin
      ptr_step_s = ptr_r - PTR_W'(1);
    end else begin
      ptr_step_s = ptr_r + PTR_W'(1);
    end
  end

  // Occupancy tracks the slots' next full flags so it stays in step with them.
  always_comb begin
    occ_nxt_s = '0;
    for (int i = 0; i < ROWS; i++) begin
      occ_nxt_s = occ_nxt_s + CNT_W'(full_nxt_s[i]);
    end
  end

  // Drain pointer, order latch, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r   <= '0;
      order_r <= ORD_FWD;
      occ_r   <= '0;
      ovf_r   <= 1'b0;
    end else begin
      occ_r <= occ_nxt_s;
      if (|ovf_pulse_s) begin
        ovf_r <= 1'b1;
      end else if (clr_ovf) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
      // Order only changes between tiles; the pointer is re-homed with it.
      if (!busy_s) begin
        order_r <= drain_order_e'(rev_order);
        ptr_r   <= rev_order ? LAST_IDX : PTR_W'(0);
      end else if (hs_s) begin
        ptr_r <= ptr_step_s;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  assign out_data  = slot_data_s[ptr_r];
  assign out_row   = ptr_r;
  assign out_valid = valid_s;
  assign out_last  = valid_s && (ptr_r == last_row_s);
  assign occupancy = occ_r;
  assign busy      = busy_s;
  assign overflow  = ovf_r;

endmodule

// File: tb/tb_col_drain_buffer.sv
// Self-checking bench for col_drain_buffer (ROWS=8): a scoreboard queue of
// expected beats is filled as rows are written and drained by a beat monitor.
module tb_col_drain_buffer;

  localparam int ROWS = 8;
  localparam int W    = 32;

  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   row;
    logic         last;
  } beat_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_r [0:ROWS-1];
  logic         in_v [0:ROWS-1];
  logic         rev_order;
  logic         clr_ovf;
  logic [W-1:0] out_data;
  logic [2:0]   out_row;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [3:0]   occupancy;
  logic         busy;
  logic         overflow;

  beat_t sb_q[$];
  int    n_cmp;
  int    n_err;

  col_drain_buffer #(
    .ROWS     (ROWS),
    .OUTWIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_r      (in_r),
    .in_v      (in_v),
    .rev_order (rev_order),
    .clr_ovf   (clr_ovf),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .occupancy (occupancy),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input int data, input int row, input bit last);
    beat_t b;
    b.data = W'(data);
    b.row  = 3'(row);
    b.last = last;
    sb_q.push_back(b);
  endtask

  // Beat monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_beat", {32'd0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        beat_t e;
        e = sb_q.pop_front();
        check_val("beat_data", 64'(out_data), 64'(e.data));
        check_val("beat_row",  64'(out_row),  64'(e.row));
        check_val("beat_last", 64'(out_last), 64'(e.last));
      end
    end
  end

  // Drive one cycle of writes on the masked rows; returns at posedge+1.
  task automatic fill(input logic [7:0] mask, input int base);
    for (int i = 0; i < ROWS; i++) begin
      in_v[i] = mask[i];
      in_r[i] = W'(base + i);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < ROWS; i++) in_v[i] = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("drain_done", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_valid"}, 64'(out_valid), 64'd0);
    check_val({tag, "_last"},  64'(out_last),  64'd0);
    check_val({tag, "_row"},   64'(out_row),   64'd0);
    check_val({tag, "_data"},  64'(out_data),  64'd0);
    check_val({tag, "_occ"},   64'(occupancy), 64'd0);
    check_val({tag, "_busy"},  64'(busy),      64'd0);
    check_val({tag, "_ovf"},   64'(overflow),  64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    rev_order = 1'b0;
    clr_ovf = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      in_v[i] = 1'b0;
      in_r[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Forward drain of a full column.
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < ROWS; i++) push_beat(100 + i, i, i == ROWS - 1);
    fill(8'hFF, 100);
    wait_drain(50);
    @(negedge clk);
    check_val("fwd_busy_after", 64'(busy), 64'd0);
    check_val("fwd_occ_after", 64'(occupancy), 64'd0);

    // Reverse drain; flipping rev_order mid-drain must not change order.
    @(posedge clk); #1;
    rev_order = 1'b1;
    @(posedge clk); #1;
    for (int i = ROWS - 1; i >= 0; i--) push_beat(100 + i, i, i == 0);
    fill(8'hFF, 100);
    @(posedge clk); #1;
    rev_order = 1'b0;
    wait_drain(50);
    @(negedge clk);
    check_val("rev_busy_after", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // Strict ordering: rows 1..7 wait behind an empty row 0.
    fill(8'hFE, 200);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val("gap_valid", 64'(out_valid), 64'd0);
      check_val("gap_occ", 64'(occupancy), 64'd7);
    end
    @(posedge clk); #1;
    push_beat(55, 0, 1'b0);
    for (int i = 1; i < ROWS; i++) push_beat(200 + i, i, i == ROWS - 1);
    in_v[0] = 1'b1;
    in_r[0] = W'(55);
    @(posedge clk); #1;
    in_v[0] = 1'b0;
    wait_drain(50);

    // Stall with a dropped write to a full row, then clear the overflow.
    out_ready = 1'b0;
    for (int i = 0; i < ROWS; i++) push_beat(300 + i, i, i == ROWS - 1);
    fill(8'hFF, 300);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val("stall_data", 64'(out_data), 64'd300);
      check_val("stall_row", 64'(out_row), 64'd0);
      check_val("stall_occ", 64'(occupancy), 64'd8);
      check_val("stall_ovf", 64'(overflow), 64'(c >= 3));
      @(posedge clk); #1;
      in_v[3] = (c == 1);
      in_r[3] = W'(999);
    end
    in_v[3] = 1'b0;
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    @(negedge clk);
    check_val("ovf_cleared", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain(50);

    // Same-cycle refill of the slot being drained.
    out_ready = 1'b0;
    for (int i = 0; i < ROWS; i++) push_beat(400 + i, i, i == ROWS - 1);
    push_beat(77, 0, 1'b0);
    fill(8'hFF, 400);
    out_ready = 1'b1;
    in_v[0] = 1'b1;
    in_r[0] = W'(77);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_v[0] = 1'b0;
    @(negedge clk);
    check_val("refill_occ", 64'(occupancy), 64'd8);
    check_val("refill_ovf", 64'(overflow), 64'd0);
    check_val("refill_next_data", 64'(out_data), 64'd401);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain(50);
    @(negedge clk);
    check_val("refill_busy_ptr", 64'(busy), 64'd1);

    // Reset in the middle of a drain, then a fresh tile from row 0.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_beat(500 + i, i, 1'b0);
    fill(8'hFF, 500);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b0;
    check_val("mid_beats", 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < ROWS; i++) push_beat(600 + i, i, i == ROWS - 1);
    fill(8'hFF, 600);
    wait_drain(50);
    @(negedge clk);
    check_val("final_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
